// File: rtl/fun_dispatcher.sv
// Job feeder for the fun core: buffers (a,b) jobs in a FIFO, runs one job at a
// time through the start/busy handshake and returns tagged results with a timeout flag.
module fun_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 2000,
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       core_a,
  output logic [7:0]       core_b,
  output logic             core_start,
  input  logic             core_busy,
  input  logic [10:0]      core_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_GAP, S_WAIT, S_OUT} state_t;

  state_t            state, state_nx;
  logic [7:0]        mem_a [DEPTH];
  logic [7:0]        mem_b [DEPTH];
  logic [AW:0]       wptr, rptr;
  logic [CW-1:0]     to_cnt;
  logic [TAG_W-1:0]  tag_cnt;
  logic              full, empty, push, pop, expire;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty      = (wptr == rptr);
  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign in_ready   = rst && !full;
  assign push       = in_valid && in_ready;
  assign expire     = core_busy && (to_cnt == CW'(TIMEOUT - 1));
  assign core_start = (state == S_START);
  assign out_valid  = (state == S_OUT);

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      S_IDLE:  if (!empty && !core_busy) begin
                 pop      = 1'b1;
                 state_nx = S_START;
               end
      S_START: state_nx = S_GAP;
      S_GAP:   state_nx = S_WAIT;
      S_WAIT:  if (!core_busy || expire) state_nx = S_OUT;
      S_OUT:   if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wptr[AW-1:0]] <= in_a;
      mem_b[wptr[AW-1:0]] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      tag_cnt    <= '0;
      to_cnt     <= '0;
      core_a     <= '0;
      core_b     <= '0;
      out_result <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop) begin
        rptr    <= rptr + (AW+1)'(1);
        core_a  <= mem_a[rptr[AW-1:0]];
        core_b  <= mem_b[rptr[AW-1:0]];
        out_tag <= tag_cnt;
        tag_cnt <= tag_cnt + TAG_W'(1);
      end
      if (state == S_GAP) to_cnt <= '0;
      if (state == S_WAIT) begin
        if (!core_busy) begin
          out_result <= core_result;
          out_err    <= 1'b0;
        end else if (expire) begin
          out_result <= '0;
          out_err    <= 1'b1;
        end else begin
          to_cnt <= to_cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_fun_dispatcher.sv
// Bench for fun_dispatcher: behavioural core, queue-based scoreboard checked every
// cycle, and directed jobs with hand-computed results.
module tb_fun_dispatcher;
  localparam int DEPTH = 4, TIMEOUT = 20, TAG_W = 8;

  logic clk = 1'b0, rst;
  logic in_valid, in_ready, core_start, core_busy, out_valid, out_ready, out_err;
  logic [7:0] in_a, in_b, core_a, core_b;
  logic [10:0] core_result, out_result;
  logic [TAG_W-1:0] out_tag;

  fun_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_a(core_a), .core_b(core_b), .core_start(core_start), .core_busy(core_busy),
    .core_result(core_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_err(out_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int lat = 1;
  bit hang = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // a * floor(cbrt(b))
  function automatic logic [10:0] ref_fun(input logic [7:0] a, input logic [7:0] b);
    int r = 0;
    for (int k = 1; k <= 6; k++) if (k * k * k <= int'(b)) r = k;
    return 11'(int'(a) * r);
  endfunction

  // Core: busy rises the edge after start, falls after 'lat' busy cycles unless hung.
  logic [7:0] pa, pb;
  int busy_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_busy <= 1'b0; core_result <= '0; busy_cnt <= 0; pa <= '0; pb <= '0;
    end else if (core_start) begin
      pa <= core_a; pb <= core_b; busy_cnt <= lat; core_busy <= 1'b1;
    end else if (core_busy && !hang) begin
      if (busy_cnt <= 1) begin
        core_busy <= 1'b0; core_result <= ref_fun(pa, pb);
      end else busy_cnt <= busy_cnt - 1;
    end
  end

  typedef struct packed { logic [7:0] a; logic [7:0] b; } job_t;
  typedef struct { logic [10:0] res; logic [7:0] tag; logic err; int due; } exp_t;
  job_t mq[$];
  exp_t expq[$];
  int cyc = 0, occ = 0;
  logic [7:0] mtag = '0, last_a = '0, last_b = '0;
  bit front_seen = 1'b0, prev_start = 1'b0;

  // Scoreboard: every signal compared on the falling edge.
  always @(negedge clk) begin
    job_t j;
    exp_t e;
    cyc++;
    if (!rst) begin
      chk("reset_outs", {in_ready, core_start, out_valid, out_err, out_result, out_tag, core_a, core_b}, 64'd0);
      mq.delete(); expq.delete();
      occ = 0; mtag = '0; last_a = '0; last_b = '0; front_seen = 1'b0; prev_start = 1'b0;
    end else begin
      if (core_start) begin
        chk("start_busy", core_busy, 0);
        chk("start_pending", expq.size(), 0);
        chk("start_pulse", prev_start, 0);
        if (mq.size() == 0) chk("start_unexpected", 1, 0);
        else begin
          j = mq.pop_front();
          occ--;
          chk("core_a", core_a, j.a);
          chk("core_b", core_b, j.b);
          e.err = hang;
          e.res = hang ? 11'd0 : ref_fun(j.a, j.b);
          e.tag = mtag;
          e.due = cyc + (hang ? TIMEOUT : lat) + 2;
          mtag = mtag + 8'd1;
          expq.push_back(e);
          last_a = j.a; last_b = j.b;
        end
      end else chk("core_hold", {core_a, core_b}, {last_a, last_b});
      prev_start = core_start;
      chk("in_ready", in_ready, occ < DEPTH);
      if (in_valid && in_ready) begin
        j.a = in_a; j.b = in_b;
        mq.push_back(j);
        occ++;
      end
      if (expq.size() > 0 && !front_seen && (out_valid || cyc == expq[0].due)) begin
        chk("out_timing", {31'd0, out_valid, cyc}, {31'd0, 1'b1, expq[0].due});
        front_seen = 1'b1;
      end
      if (out_valid) begin
        if (expq.size() == 0) chk("out_unexpected", 1, 0);
        else begin
          chk("out_result", out_result, expq[0].res);
          chk("out_tag", out_tag, expq[0].tag);
          chk("out_err", out_err, expq[0].err);
          if (out_ready) begin expq.delete(0); front_seen = 1'b0; end
        end
      end
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    if (!in_ready) chk("push_wait", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input logic [10:0] res, input logic [7:0] tag, input logic err);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 300) begin n++; @(negedge clk); end
    if (!out_valid) chk("out_wait", 0, 1);
    else begin
      chk("lit_result", out_result, res);
      chk("lit_tag", out_tag, tag);
      chk("lit_err", out_err, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #1 chk("init_ready", in_ready, 0);
    chk("init_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // single job through the core
    push(8'd5, 8'd27);
    n = 0;
    @(negedge clk);
    while (!core_start && n < 50) begin n++; @(negedge clk); end
    chk("t1_start", core_start, 1);
    chk("t1_core", {core_a, core_b}, {8'd5, 8'd27});
    wait_out(11'd15, 8'd0, 1'b0);

    // back-to-back burst
    do_reset();
    push(8'd3, 8'd64); push(8'd9, 8'd125); push(8'd255, 8'd200); push(8'd97, 8'd0);
    wait_out(11'd12, 8'd0, 1'b0);
    wait_out(11'd45, 8'd1, 1'b0);
    wait_out(11'd1275, 8'd2, 1'b0);
    wait_out(11'd0, 8'd3, 1'b0);

    // back-pressure while the FIFO fills behind the held result
    out_ready = 1'b0;
    push(8'd84, 8'd84);
    wait_out(11'd336, 8'd4, 1'b0);
    fork
      begin
        push(8'd1, 8'd1); push(8'd2, 8'd8); push(8'd3, 8'd27); push(8'd4, 8'd64); push(8'd5, 8'd125);
      end
      begin
        repeat (50) @(posedge clk);
        #1;
        chk("bp_full", in_ready, 0);
        chk("bp_hold", {out_valid, out_result, out_tag}, {1'b1, 11'd336, 8'd4});
        out_ready = 1'b1;
      end
      begin
        wait (out_ready);
        @(posedge clk); #1;
        wait_out(11'd1, 8'd5, 1'b0);
        wait_out(11'd4, 8'd6, 1'b0);
        wait_out(11'd9, 8'd7, 1'b0);
        wait_out(11'd16, 8'd8, 1'b0);
        wait_out(11'd25, 8'd9, 1'b0);
      end
    join

    // hung core: timeout, then no launch until busy drops
    hang = 1'b1;
    push(8'd7, 8'd8); push(8'd2, 8'd27);
    wait_out(11'd0, 8'd10, 1'b1);
    n = 0;
    repeat (30) begin @(negedge clk); if (core_start) n++; end
    chk("no_launch_busy", n, 0);
    @(posedge clk); #1 hang = 1'b0;
    wait_out(11'd6, 8'd11, 1'b0);

    // async reset mid-job with two jobs queued
    lat = 10;
    push(8'd10, 8'd1); push(8'd11, 8'd1); push(8'd12, 8'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("async_rst", {in_ready, core_start, out_valid, out_err, out_result, out_tag, core_a, core_b}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rel_ready", in_ready, 1);
    lat = 1;
    repeat (5) @(posedge clk);
    #1;
    push(8'd5, 8'd27);
    wait_out(11'd15, 8'd0, 1'b0);

    // tag wrap over 257 jobs
    do_reset();
    for (int j = 0; j < 257; j++) begin
      push(8'd101, 8'd2);
      wait_out(11'd101, 8'(j), 1'b0);
    end

    repeat (10) @(posedge clk);
    chk("drain", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
